// File: rtl/operand_stepper.sv
// operand_stepper: generates a run of operand pairs (A, B) for a downstream adder.
// Each beat k (1..count) presents A = init_a + k*STEP_A and B = init_b + k*STEP_B
// over a valid/ready handshake, then pulses done for one cycle.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, count          begin a run of count beats (sampled only in IDLE)
//   init_a, init_b        starting operand values, latched on the start edge
//   out_ready             downstream accepts the presented beat
//   out_valid, out_a/b    presented beat; out_a/out_b hold the last beat when not valid
//   busy, done            high while running; one-cycle completion pulse
// Build option: define OPERAND_STEPPER_SAT_EN to clamp steps at the signed
// bounds instead of wrapping modulo 2^WIDTH.
module operand_stepper #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 8,
    parameter int STEP_A = 1,
    parameter int STEP_B = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] init_a,
    input  logic [WIDTH-1:0] init_b,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input int s);
`ifdef OPERAND_STEPPER_SAT_EN
        logic signed [WIDTH:0] sum;
        sum = $signed({v[WIDTH-1], v}) + (WIDTH+1)'(s);
        // overflow when the extra sign bit disagrees; clamp toward its sign
        return (sum[WIDTH] != sum[WIDTH-1]) ? {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}}
                                            : sum[WIDTH-1:0];
`else
        return v + WIDTH'(s);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (count == '0) ? DONE : RUN;
            RUN:     if (out_ready && cnt == CNT_W'(1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are stepped one beat ahead: the start edge loads beat 1 and each
    // transfer loads the next, so the final beat stays on out_a/out_b afterwards.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_a <= '0;
            out_b <= '0;
            cnt   <= '0;
        end else if (state == IDLE && start) begin
            cnt <= count;
            if (count != '0) begin
                out_a <= step(init_a, STEP_A);
                out_b <= step(init_b, STEP_B);
            end
        end else if (state == RUN && out_ready) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt != CNT_W'(1)) begin
                out_a <= step(out_a, STEP_A);
                out_b <= step(out_b, STEP_B);
            end
        end

    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
endmodule

// File: tb/tb_operand_stepper.sv
// tb_operand_stepper: directed self-checking bench for operand_stepper with
// default parameters (WIDTH=32, CNT_W=8, STEP_A=1, STEP_B=2).
module tb_operand_stepper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  count = '0;
    logic [31:0] init_a = '0;
    logic [31:0] init_b = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    operand_stepper dut (
        .clk(clk), .rst_n(rst_n), .start(start), .count(count),
        .init_a(init_a), .init_b(init_b), .out_ready(out_ready),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic bz, input logic d);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".a"},     64'(out_a),     64'(a));
        chk({tag, ".b"},     64'(out_b),     64'(b));
        chk({tag, ".busy"},  64'(busy),      64'(bz));
        chk({tag, ".done"},  64'(done),      64'(d));
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #2;
        chk_all("reset", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        nxt();
        rst_n = 1'b1;

        // 8 back-to-back beats from 0/0
        start = 1'b1; count = 8'd8; out_ready = 1'b1;
        nxt();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk_all($sformatf("run8.beat%0d", k), 1'b1, 32'(k), 32'(2*k), 1'b1, 1'b0);
            nxt();
        end
        chk_all("run8.done", 1'b0, 32'd8, 32'd16, 1'b0, 1'b1);
        nxt();
        chk_all("run8.idle", 1'b0, 32'd8, 32'd16, 1'b0, 1'b0);

        // count=3 with 4-cycle stall on beat 2
        start = 1'b1; count = 8'd3;
        nxt();
        start = 1'b0;
        chk_all("stall.beat1", 1'b1, 32'd1, 32'd2, 1'b1, 1'b0);
        nxt();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("stall.hold%0d", i), 1'b1, 32'd2, 32'd4, 1'b1, 1'b0);
            nxt();
        end
        out_ready = 1'b1;
        chk_all("stall.beat2", 1'b1, 32'd2, 32'd4, 1'b1, 1'b0);
        nxt();
        chk_all("stall.beat3", 1'b1, 32'd3, 32'd6, 1'b1, 1'b0);
        nxt();
        chk_all("stall.done", 1'b0, 32'd3, 32'd6, 1'b0, 1'b1);
        nxt();
        chk_all("stall.idle", 1'b0, 32'd3, 32'd6, 1'b0, 1'b0);

        // count=0: straight to DONE, no beats, outputs keep last beat
        start = 1'b1; count = 8'd0; init_a = 32'd100; init_b = 32'd200;
        nxt();
        start = 1'b0;
        chk_all("zero.done", 1'b0, 32'd3, 32'd6, 1'b0, 1'b1);
        nxt();
        chk_all("zero.idle", 1'b0, 32'd3, 32'd6, 1'b0, 1'b0);

        // positive overflow of A
        start = 1'b1; count = 8'd2; init_a = 32'h7FFF_FFFF; init_b = 32'd0;
        nxt();
        start = 1'b0;
`ifdef OPERAND_STEPPER_SAT_EN
        chk_all("ovf.beat1", 1'b1, 32'h7FFF_FFFF, 32'd2, 1'b1, 1'b0);
        nxt();
        chk_all("ovf.beat2", 1'b1, 32'h7FFF_FFFF, 32'd4, 1'b1, 1'b0);
`else
        chk_all("ovf.beat1", 1'b1, 32'h8000_0000, 32'd2, 1'b1, 1'b0);
        nxt();
        chk_all("ovf.beat2", 1'b1, 32'h8000_0001, 32'd4, 1'b1, 1'b0);
`endif
        nxt();
        chk("ovf.done", 64'(done), 64'd1);
        nxt();

        // asynchronous reset at beat 4 of 8
        start = 1'b1; count = 8'd8; init_a = 32'd0; init_b = 32'd0;
        nxt();
        start = 1'b0;
        nxt(); nxt(); nxt();
        chk_all("rst.beat4", 1'b1, 32'd4, 32'd8, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("rst.async", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        nxt();
        chk_all("rst.held", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        start = 1'b1; count = 8'd8;
        nxt();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk_all($sformatf("rerun.beat%0d", k), 1'b1, 32'(k), 32'(2*k), 1'b1, 1'b0);
            nxt();
        end
        chk("rerun.done", 64'(done), 64'd1);
        nxt();

        // start held high through RUN and DONE
        start = 1'b1; count = 8'd2; init_a = 32'd10; init_b = 32'd20;
        nxt();
        chk_all("hold.r1b1", 1'b1, 32'd11, 32'd22, 1'b1, 1'b0);
        nxt();
        chk_all("hold.r1b2", 1'b1, 32'd12, 32'd24, 1'b1, 1'b0);
        nxt();
        chk_all("hold.done", 1'b0, 32'd12, 32'd24, 1'b0, 1'b1);
        nxt();
        chk_all("hold.idle", 1'b0, 32'd12, 32'd24, 1'b0, 1'b0);
        nxt();
        start = 1'b0;
        chk_all("hold.r2b1", 1'b1, 32'd11, 32'd22, 1'b1, 1'b0);
        nxt();
        chk_all("hold.r2b2", 1'b1, 32'd12, 32'd24, 1'b1, 1'b0);
        nxt();
        chk_all("hold.r2done", 1'b0, 32'd12, 32'd24, 1'b0, 1'b1);
        nxt();
        chk_all("hold.r2idle", 1'b0, 32'd12, 32'd24, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operand_stepper.md
OPERAND_STEPPER -- requirements
Module: operand_stepper

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits (signed two's complement).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the beat-count width.
REQ-003 The block SHALL have parameter STEP_A, default 1, giving the signed per-beat increment of operand A.
REQ-004 The block SHALL have parameter STEP_B, default 2, giving the signed per-beat increment of operand B.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- count  in  CNT_W  number of beats in the run.
- init_a  in  WIDTH  starting value of A.
- init_b  in  WIDTH  starting value of B.
- out_ready  in  1  downstream adder accepts the beat.
- out_valid  out  1  out_a/out_b hold a valid beat.
- out_a  out  WIDTH  operand A to the downstream adder.
- out_b  out  WIDTH  operand B to the downstream adder.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-007 In IDLE with start=1, the block SHALL latch init_a, init_b and count on that edge.
REQ-008 From IDLE with start=1 and count!=0, the block SHALL enter RUN on the next edge.
REQ-009 From IDLE with start=1 and count=0, the block SHALL enter DONE directly and emit zero beats.
REQ-010 In RUN, beat k (k=1..count) SHALL present out_a=init_a+k*STEP_A and out_b=init_b+k*STEP_B, i.e. increment before use.
REQ-011 The first beat SHALL be valid on the cycle after the start edge (latency 1).
REQ-012 A beat SHALL transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-013 After a transfer, the next beat SHALL be presented on the following cycle (no bubble) while beats remain.
REQ-014 While out_valid=1 and out_ready=0, out_a, out_b and out_valid SHALL remain stable.
REQ-015 out_valid SHALL not depend combinationally on out_ready.
REQ-016 On transfer of beat count, the block SHALL enter DONE; out_valid SHALL drop the next cycle.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 start SHALL be ignored in RUN and DONE.
REQ-019 A new start SHALL be accepted in the first IDLE cycle after DONE.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 out_valid SHALL be 0 outside RUN.
REQ-022 out_a and out_b SHALL hold the last transferred beat when not valid.
REQ-023 The internal beat counter SHALL be CNT_W bits and count down to zero; count=2^CNT_W-1 SHALL yield exactly that many beats.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, out_valid=0, busy=0, done=0, out_a=0, out_b=0 and clear the counter, regardless of clock.
REQ-025 Reset mid-RUN SHALL abandon the run with no done pulse.
REQ-026 After rst_n rises, the first start SHALL be honoured on the first clock edge.

Configuration
REQ-027 With OPERAND_STEPPER_SAT_EN defined, an out_a/out_b step that would exceed 2^(WIDTH-1)-1 or fall below -2^(WIDTH-1) SHALL clamp to that bound and stay there for the rest of the run.
REQ-028 With OPERAND_STEPPER_SAT_EN undefined, the step arithmetic SHALL wrap modulo 2^WIDTH.
REQ-029 The port list SHALL be identical in both configurations.

Verification
REQ-030 init_a=0, init_b=0, count=8, out_ready=1 -> 8 back-to-back beats; A=1..8, B=2,4..16; done pulse 1 cycle after the beat-8 transfer.
REQ-031 count=3 with out_ready low for 4 cycles on beat 2 -> beat 2 (A=2, B=4) held stable; then beat 3; done fires once.
REQ-032 count=0 with start -> no out_valid; done high the cycle after start; busy never high.
REQ-033 init_a=32'h7FFFFFFF, count=2 -> without macro A=32'h80000000, 32'h80000001; with macro A=32'h7FFFFFFF twice.
REQ-034 rst_n low mid-run at beat 4 of 8 -> outputs zero asynchronously; no done pulse; fresh start after release runs from beat 1.
REQ-035 start held high through RUN and DONE -> only one run counted; a second run starts in the first IDLE cycle.
